// File: rtl/riscv_mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter.
package riscv_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_IF,
        WAIT_D
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_e;

endpackage

// File: rtl/riscv_arb_starve_ctr.sv
// Saturating count of data grants won while a fetch is waiting.
module riscv_arb_starve_ctr #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int unsigned W = $clog2(STARVE_MAX + 1);
    localparam logic [W-1:0] MAX_C = W'(STARVE_MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != MAX_C)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and
// load/store; data has priority, bounded by a fetch starvation counter.
module riscv_mem_arbiter
    import riscv_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                proto_err_o
);

    arb_state_e state_q, state_d;
    owner_e     lock_q, lock_d;
    owner_e     win;
    logic       proto_err_q, proto_err_d;
    logic       starve_sat;

    riscv_arb_starve_ctr #(
        .STARVE_MAX(STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .reset (reset),
        .inc_i (d_gnt_o && if_req_i),
        .clr_i (if_gnt_o || !if_req_i),
        .sat_o (starve_sat)
    );

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        proto_err_d = proto_err_q;
        win         = OWN_NONE;
        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_gnt_o     = 1'b0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        unique case (state_q)
            IDLE: begin
                // A request shown to memory but not yet granted keeps the bus
                if (lock_q != OWN_NONE) begin
                    win = lock_q;
                end else if (d_req_i && !(if_req_i && starve_sat)) begin
                    win = OWN_D;
                end else if (if_req_i) begin
                    win = OWN_IF;
                end

                if (win == OWN_D) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = d_we_i;
                    mem_be_o    = d_be_i;
                    mem_addr_o  = d_addr_i;
                    mem_wdata_o = d_wdata_i;
                end else if (win == OWN_IF) begin
                    mem_req_o  = 1'b1;
                    mem_be_o   = '1;
                    mem_addr_o = if_addr_i;
                end

                if (win != OWN_NONE) begin
                    if (mem_gnt_i) begin
                        lock_d = OWN_NONE;
                        if (win == OWN_IF) begin
                            if_gnt_o = 1'b1;
                            state_d  = WAIT_IF;
                        end else begin
                            d_gnt_o = 1'b1;
                            state_d = WAIT_D;
                        end
                    end else begin
                        lock_d = win;
                    end
                end

                if (mem_rvalid_i) begin
                    proto_err_d = 1'b1;
                end
            end
            WAIT_IF: begin
                if (mem_rvalid_i) begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = mem_rdata_i;
                    state_d     = IDLE;
                end
            end
            WAIT_D: begin
                if (mem_rvalid_i) begin
                    d_rvalid_o = 1'b1;
                    d_rdata_o  = mem_rdata_i;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reset) begin
            if_gnt_o    = 1'b0;
            if_rvalid_o = 1'b0;
            if_rdata_o  = '0;
            d_gnt_o     = 1'b0;
            d_rvalid_o  = 1'b0;
            d_rdata_o   = '0;
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            mem_be_o    = '0;
            mem_addr_o  = '0;
            mem_wdata_o = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lock_q      <= OWN_NONE;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with hand-computed expectations.
module tb_riscv_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_gnt_o;
    logic        if_rvalid_o;
    logic [31:0] if_rdata_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [3:0]  d_be_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic        d_gnt_o;
    logic        d_rvalid_o;
    logic [31:0] d_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        proto_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_mem_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .if_req_i     (if_req_i),
        .if_addr_i    (if_addr_i),
        .if_gnt_o     (if_gnt_o),
        .if_rvalid_o  (if_rvalid_o),
        .if_rdata_o   (if_rdata_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_be_i       (d_be_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_gnt_o      (d_gnt_o),
        .d_rvalid_o   (d_rvalid_o),
        .d_rdata_o    (d_rdata_o),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_be_o     (mem_be_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .proto_err_o  (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        if_req_i     = 1'b1;
        if_addr_i    = 32'h0;
        d_req_i      = 1'b1;
        d_we_i       = 1'b1;
        d_be_i       = 4'hF;
        d_addr_i     = 32'h44;
        d_wdata_i    = 32'h55;
        mem_gnt_i    = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hA5A5A5A5;

        // Reset: outputs forced quiet even with active inputs
        tick();
        chkb("rst_mem_req", mem_req_o, 1'b0);
        chkb("rst_if_gnt", if_gnt_o, 1'b0);
        chkb("rst_d_gnt", d_gnt_o, 1'b0);
        chkb("rst_if_rvalid", if_rvalid_o, 1'b0);
        chk("rst_d_rdata", d_rdata_o, 32'h0);
        chkb("rst_proto_err", proto_err_o, 1'b0);
        if_req_i     = 1'b0;
        d_req_i      = 1'b0;
        d_we_i       = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
        #2 reset = 1'b0;

        // 1: fetch only
        tick();
        if_req_i  = 1'b1;
        if_addr_i = 32'h0;
        mem_gnt_i = 1'b1;
        #1;
        chkb("t1_if_gnt", if_gnt_o, 1'b1);
        chkb("t1_mem_req", mem_req_o, 1'b1);
        chk("t1_mem_addr", mem_addr_o, 32'h0);
        chkb("t1_mem_we", mem_we_o, 1'b0);
        chkb("t1_d_gnt", d_gnt_o, 1'b0);
        tick();
        if_req_i     = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00500093;
        #1;
        chkb("t1_if_rvalid", if_rvalid_o, 1'b1);
        chk("t1_if_rdata", if_rdata_o, 32'h00500093);
        chkb("t1_d_rvalid", d_rvalid_o, 1'b0);
        chk("t1_d_rdata", d_rdata_o, 32'h0);
        chkb("t1_wait_no_req", mem_req_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chkb("t1_if_rvalid_low", if_rvalid_o, 1'b0);
        chk("t1_if_rdata_zero", if_rdata_o, 32'h0);

        // 2: simultaneous, data store wins
        if_req_i  = 1'b1;
        if_addr_i = 32'h4;
        d_req_i   = 1'b1;
        d_we_i    = 1'b1;
        d_be_i    = 4'hF;
        d_addr_i  = 32'h100;
        d_wdata_i = 32'hDEADBEEF;
        mem_gnt_i = 1'b1;
        #1;
        chkb("t2_d_gnt", d_gnt_o, 1'b1);
        chkb("t2_if_gnt", if_gnt_o, 1'b0);
        chkb("t2_mem_we", mem_we_o, 1'b1);
        chk("t2_mem_addr", mem_addr_o, 32'h100);
        chk("t2_mem_wdata", mem_wdata_o, 32'hDEADBEEF);
        chk("t2_mem_be", 32'(mem_be_o), 32'hF);
        tick();
        d_req_i = 1'b0;
        d_we_i  = 1'b0;
        #1;
        chkb("t2_wait_no_req", mem_req_o, 1'b0);
        chkb("t2_wait_no_ifgnt", if_gnt_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h12345678;
        #1;
        chkb("t2_d_ack", d_rvalid_o, 1'b1);
        chk("t2_d_rdata", d_rdata_o, 32'h12345678);
        chkb("t2_if_rvalid", if_rvalid_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chkb("t2_if_gnt_after", if_gnt_o, 1'b1);
        chk("t2_if_addr", mem_addr_o, 32'h4);
        chkb("t2_if_we", mem_we_o, 1'b0);
        tick();
        if_req_i     = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00000013;
        #1;
        chkb("t2_if_rvalid", if_rvalid_o, 1'b1);
        tick();
        mem_rvalid_i = 1'b0;

        // 3: starvation bound
        if_req_i  = 1'b1;
        if_addr_i = 32'h8;
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        for (int k = 0; k < 4; k++) begin
            d_addr_i     = 32'h200 + 32'(4 * k);
            mem_gnt_i    = 1'b1;
            mem_rvalid_i = 1'b0;
            #1;
            chkb($sformatf("t3_d_gnt%0d", k), d_gnt_o, 1'b1);
            chkb($sformatf("t3_if_wait%0d", k), if_gnt_o, 1'b0);
            tick();
            mem_gnt_i    = 1'b0;
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = 32'h1000 + 32'(k);
            #1;
            chk($sformatf("t3_cnt%0d", k),
                32'(dut.u_starve.cnt_q), 32'(k + 1));
            chkb($sformatf("t3_d_rv%0d", k), d_rvalid_o, 1'b1);
            tick();
        end
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b1;
        #1;
        chkb("t3_if_forced", if_gnt_o, 1'b1);
        chkb("t3_d_held", d_gnt_o, 1'b0);
        chk("t3_if_addr", mem_addr_o, 32'h8);
        tick();
        if_req_i     = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00A00113;
        #1;
        chk("t3_cnt_clr", 32'(dut.u_starve.cnt_q), 32'h0);
        chkb("t3_if_rvalid", if_rvalid_o, 1'b1);
        tick();
        d_req_i      = 1'b0;
        mem_rvalid_i = 1'b0;

        // 4: stalled fetch keeps its lock over a late data request
        tick();
        if_req_i  = 1'b1;
        if_addr_i = 32'h40;
        #1;
        chkb("t4_req", mem_req_o, 1'b1);
        chk("t4_addr_s1", mem_addr_o, 32'h40);
        chkb("t4_no_gnt", if_gnt_o, 1'b0);
        tick();
        d_req_i  = 1'b1;
        d_we_i   = 1'b0;
        d_addr_i = 32'h300;
        #1;
        chk("t4_addr_s2", mem_addr_o, 32'h40);
        chkb("t4_d_no_gnt", d_gnt_o, 1'b0);
        tick();
        chk("t4_addr_s3", mem_addr_o, 32'h40);
        tick();
        mem_gnt_i = 1'b1;
        #1;
        chkb("t4_if_gnt", if_gnt_o, 1'b1);
        chkb("t4_d_gnt0", d_gnt_o, 1'b0);
        tick();
        if_req_i     = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hCAFE0001;
        #1;
        chkb("t4_if_rvalid", if_rvalid_o, 1'b1);
        chk("t4_if_rdata", if_rdata_o, 32'hCAFE0001);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chkb("t4_d_gnt", d_gnt_o, 1'b1);
        chk("t4_d_addr", mem_addr_o, 32'h300);
        tick();
        d_req_i      = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h77;
        #1;
        chkb("t4_d_rvalid", d_rvalid_o, 1'b1);
        tick();
        mem_rvalid_i = 1'b0;

        // 5: stray response in IDLE
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFF;
        #1;
        chkb("t5_if_rv", if_rvalid_o, 1'b0);
        chkb("t5_d_rv", d_rvalid_o, 1'b0);
        chk("t5_d_rdata", d_rdata_o, 32'h0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chkb("t5_err_set", proto_err_o, 1'b1);
        tick();
        tick();
        chkb("t5_err_sticky", proto_err_o, 1'b1);
        reset = 1'b1;
        #1;
        chkb("t5_err_clr", proto_err_o, 1'b0);
        #1 reset = 1'b0;

        // 6: reset abandons an outstanding load
        tick();
        d_req_i   = 1'b1;
        d_we_i    = 1'b0;
        d_addr_i  = 32'h80;
        mem_gnt_i = 1'b1;
        #1;
        chkb("t6_d_gnt", d_gnt_o, 1'b1);
        tick();
        d_req_i   = 1'b0;
        mem_gnt_i = 1'b0;
        #1;
        chkb("t6_wait", mem_req_o, 1'b0);
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hBAD0BAD0;
        #1;
        chkb("t6_d_rv", d_rvalid_o, 1'b0);
        chkb("t6_if_rv", if_rvalid_o, 1'b0);
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        chkb("t6_err", proto_err_o, 1'b1);
        if_req_i  = 1'b1;
        if_addr_i = 32'hC;
        mem_gnt_i = 1'b1;
        #1;
        chkb("t6_if_gnt", if_gnt_o, 1'b1);
        chk("t6_if_addr", mem_addr_o, 32'hC);
        tick();
        if_req_i     = 1'b0;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h00000013;
        #1;
        chkb("t6_if_rv", if_rvalid_o, 1'b1);
        chk("t6_if_rdata", if_rdata_o, 32'h00000013);
        tick();
        mem_rvalid_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
